data_ram_lsu: RTL



---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_align.sv | 44 ++++
 rtl/data_ram_lsu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the data_ram load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction/extension, sub-word store merge, misalign check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mdata_o,
  output logic        misalign_o
);
  logic [31:0] sh;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    ldata_o = rdata_i;
    case (funct3_i)
      F3_B:    ldata_o = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   ldata_o = {24'h0, sh[7:0]};
      F3_H:    ldata_o = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   ldata_o = {16'h0, sh[15:0]};
      default: ldata_o = rdata_i;
    endcase

    // Untouched lanes keep the word just read from the RAM.
    mdata_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        mdata_o = rdata_i;
        mdata_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H: begin
        mdata_o = rdata_i;
        if (off_i[1]) mdata_o[31:16] = wdata_i[15:0];
        else          mdata_o[15:0]  = wdata_i[15:0];
      end
      default: mdata_o = wdata_i;
    endcase

    misalign_o = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && off_i[0]) ||
                 ((funct3_i == F3_W) && (off_i != 2'b00));
  end
endmodule

// File: rtl/data_ram_lsu.sv
// Load/store initiator for data_ram: one request at a time, RMW for SB/SH.
module data_ram_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;

  logic        idle, bad_f3, oor, req_err;
  logic [1:0]  a_off;
  logic [2:0]  a_f3;
  logic [31:0] a_wdata, a_ldata, a_mdata;
  logic        a_mis;

  // One aligner: fed from the request while idle, from latched state otherwise.
  assign idle    = (state_q == IDLE);
  assign a_off   = idle ? req_addr[1:0] : addr_q[1:0];
  assign a_f3    = idle ? req_funct3    : f3_q;
  assign a_wdata = idle ? req_wdata     : wdata_q;

  lsu_align u_align (
    .off_i     (a_off),
    .funct3_i  (a_f3),
    .rdata_i   (mem_rd),
    .wdata_i   (a_wdata),
    .ldata_o   (a_ldata),
    .mdata_o   (a_mdata),
    .misalign_o(a_mis)
  );

  assign bad_f3  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
  assign oor     = req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS);
  assign req_err = bad_f3 || a_mis || oor;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    f3_d     = f3_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        err_d    = req_err;
        result_d = 32'h0;
        // Erroring requests leave address/data regs alone so mem_a/mem_wd hold.
        if (req_err) begin
          state_d = RESP;
        end else begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == F3_W) begin
            merge_d = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        result_d = a_ldata;
        state_d  = RESP;
      end
      RMW_RD: begin
        merge_d = a_mdata;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      f3_q     <= f3_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = !rst && idle;
  assign resp_valid = !rst && (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? result_q : 32'h0;
  assign mem_re     = !rst && ((state_q == LOAD) || (state_q == RMW_RD));
  assign mem_we     = !rst && (state_q == WRITE);
  assign mem_a      = rst ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wd     = rst ? 32'h0 : merge_q;
endmodule
